// File: rtl/gmii_pkg.sv
// Shared GMII receive/transmit definitions: framing octets, CRC32 constants,
// trailer offsets, parser state encoding and the per-frame summary record.
package gmii_pkg;

  localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;
  localparam logic [2:0]  PRE_MAX       = 3'd7;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  // Trailer field offsets, counted in octets back from the end of the frame.
  localparam int SEQ_OFF     = 22;
  localparam int TS_SEC_OFF  = 14;
  localparam int TS_NSEC_OFF = 8;
  localparam int FCS_LEN     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  typedef struct packed {
    logic [15:0] len;
    logic        crc_ok;
    logic        err;
    logic        runt;
    logic        oversize;
    logic        trailer_ok;
    logic [63:0] seq;
    logic [47:0] tx_sec;
    logic [29:0] tx_nsec;
    logic [47:0] rx_sec;
    logic [29:0] rx_nsec;
  } frame_rec_t;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The datapath shifts LSB-first, so it works with the reflected polynomial.
  localparam logic [31:0] CRC32_POLY_REFL = bit_reverse32(CRC32_POLY);

endpackage

// File: rtl/crc32_gmii_byte.sv
// Combinational one-octet step of the reflected Ethernet CRC32.
// Shared by the receive FCS check and the generator's FCS insertion.
module crc32_gmii_byte
  import gmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  // NOTE: blocking assignments here are intentional; each loop pass must see
  // the value produced by the previous pass within the same evaluation.
  always_comb begin
    c = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive front end: preamble/SFD strip, FCS check, trailer extraction,
// arrival timestamp and idle-octet reporting, one summary record per frame.
module gmii_rx_frame_parser
  import gmii_pkg::*;
#(
  parameter int MAX_FRAME   = 1518,
  parameter int MIN_FRAME   = 64,
  parameter int TRAILER_LEN = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_d,
  input  logic        gmii_en,
  input  logic        gmii_er,
  input  logic [47:0] sec,
  input  logic [29:0] nsec,
  output logic        idle_octet,
  output logic        sof,
  output logic        frame_valid,
  output logic [15:0] frame_len,
  output logic        frame_crc_ok,
  output logic        frame_err,
  output logic        frame_runt,
  output logic        frame_oversize,
  output logic        frame_trailer_ok,
  output logic [63:0] frame_seq,
  output logic [47:0] frame_tx_sec,
  output logic [29:0] frame_tx_nsec,
  output logic [47:0] frame_rx_sec,
  output logic [29:0] frame_rx_nsec
);

  localparam int          SR_W        = TRAILER_LEN * 8;
  localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME);
  localparam logic [15:0] TRAILER_MIN = 16'(TRAILER_LEN);

  rx_state_e   state_q;
  logic [2:0]  pre_cnt_q;
  logic [15:0] len_q;
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [SR_W-1:0] sr_q;
  logic        err_q;
  logic [47:0] rx_sec_q;
  logic [29:0] rx_nsec_q;
  logic        idle_q;
  logic        sof_q;
  logic        valid_q;
  frame_rec_t  rec_q;
  frame_rec_t  rec_d;

  crc32_gmii_byte u_crc (
    .crc_i  (crc_q),
    .data_i (gmii_d),
    .crc_o  (crc_d)
  );

  // NOTE: rec_d gets a full default first so no path through this block can
  // leave a field unassigned and infer a latch.
  always_comb begin
    rec_d            = '0;
    rec_d.len        = len_q;
    // Residue constant is written MSB-first; the register is held reflected.
    rec_d.crc_ok     = (bit_reverse32(crc_q) == CRC32_RESIDUE);
    rec_d.err        = err_q;
    rec_d.runt       = (len_q < MIN_LEN);
    rec_d.oversize   = (len_q > MAX_LEN);
    rec_d.trailer_ok = (len_q >= TRAILER_MIN);
    rec_d.rx_sec     = rx_sec_q;
    rec_d.rx_nsec    = rx_nsec_q;
    if (rec_d.trailer_ok) begin
      rec_d.seq     = sr_q[SEQ_OFF*8-1     -: 64];
      rec_d.tx_sec  = sr_q[TS_SEC_OFF*8-1  -: 48];
      rec_d.tx_nsec = sr_q[TS_NSEC_OFF*8-3 -: 30];
    end
  end

  // NOTE: every register, the shift register included, is cleared by the
  // synchronous reset so a frame cut short by reset leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pre_cnt_q <= '0;
      len_q     <= '0;
      crc_q     <= '0;
      sr_q      <= '0;
      err_q     <= 1'b0;
      rx_sec_q  <= '0;
      rx_nsec_q <= '0;
      idle_q    <= 1'b0;
      sof_q     <= 1'b0;
      valid_q   <= 1'b0;
      rec_q     <= '0;
    end else begin
      idle_q  <= ~gmii_en;
      sof_q   <= 1'b0;
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (gmii_en) begin
            if (gmii_d == GMII_PREAMBLE) begin
              state_q   <= ST_PRE;
              pre_cnt_q <= 3'd1;
            end else begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_PRE: begin
          if (!gmii_en) begin
            state_q <= ST_IDLE;
          end else if (gmii_d == GMII_PREAMBLE) begin
            if (pre_cnt_q == PRE_MAX) state_q <= ST_DROP;
            else                      pre_cnt_q <= pre_cnt_q + 3'd1;
          end else if (gmii_d == GMII_SFD) begin
            state_q   <= ST_DATA;
            sof_q     <= 1'b1;
            rx_sec_q  <= sec;
            rx_nsec_q <= nsec;
            crc_q     <= CRC32_INIT;
            len_q     <= '0;
            err_q     <= 1'b0;
          end else begin
            state_q <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (gmii_en) begin
            sr_q  <= {sr_q[SR_W-9:0], gmii_d};
            crc_q <= crc_d;
            if (len_q != '1) len_q <= len_q + 16'd1;
            if (gmii_er)     err_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b1;
            rec_q   <= rec_d;
          end
        end
        ST_DROP: begin
          if (!gmii_en) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idle_octet       = idle_q;
  assign sof              = sof_q;
  assign frame_valid      = valid_q;
  assign frame_len        = rec_q.len;
  assign frame_crc_ok     = rec_q.crc_ok;
  assign frame_err        = rec_q.err;
  assign frame_runt       = rec_q.runt;
  assign frame_oversize   = rec_q.oversize;
  assign frame_trailer_ok = rec_q.trailer_ok;
  assign frame_seq        = rec_q.seq;
  assign frame_tx_sec     = rec_q.tx_sec;
  assign frame_tx_nsec    = rec_q.tx_nsec;
  assign frame_rx_sec     = rec_q.rx_sec;
  assign frame_rx_nsec    = rec_q.rx_nsec;

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Directed bench for gmii_rx_frame_parser: builds wire frames with a
// reference CRC32, drives them on GMII and compares each summary record.
module tb_gmii_rx_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gmii_d;
  logic        gmii_en;
  logic        gmii_er;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic        idle_octet, sof, frame_valid;
  logic [15:0] frame_len;
  logic        frame_crc_ok, frame_err, frame_runt, frame_oversize, frame_trailer_ok;
  logic [63:0] frame_seq;
  logic [47:0] frame_tx_sec, frame_rx_sec;
  logic [29:0] frame_tx_nsec, frame_rx_nsec;

  always #4 clk = ~clk;

  gmii_rx_frame_parser dut (
    .clk              (clk),
    .rst              (rst),
    .gmii_d           (gmii_d),
    .gmii_en          (gmii_en),
    .gmii_er          (gmii_er),
    .sec              (sec),
    .nsec             (nsec),
    .idle_octet       (idle_octet),
    .sof              (sof),
    .frame_valid      (frame_valid),
    .frame_len        (frame_len),
    .frame_crc_ok     (frame_crc_ok),
    .frame_err        (frame_err),
    .frame_runt       (frame_runt),
    .frame_oversize   (frame_oversize),
    .frame_trailer_ok (frame_trailer_ok),
    .frame_seq        (frame_seq),
    .frame_tx_sec     (frame_tx_sec),
    .frame_tx_nsec    (frame_tx_nsec),
    .frame_rx_sec     (frame_rx_sec),
    .frame_rx_nsec    (frame_rx_nsec)
  );

  typedef struct {
    logic [15:0] len;
    logic        crc_ok, err, runt, oversize, trailer_ok;
    logic [63:0] seq;
    logic [47:0] tx_sec, rx_sec;
    logic [29:0] tx_nsec, rx_nsec;
  } rec_t;

  int          errors = 0;
  int          checks = 0;
  rec_t        recs[$];
  rec_t        mon_r;
  logic [7:0]  fb[$];
  int          sof_cnt  = 0;
  int          idle_obs = 0;
  logic        in_win   = 1'b0;
  logic        burst_on = 1'b0;
  logic        pend_win = 1'b0;
  logic [47:0] sfd_sec;
  logic [29:0] sfd_nsec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Outputs are registered, so idle_octet seen after a posedge reflects that edge's gmii_en.
  always @(posedge clk) pend_win <= in_win;

  always @(negedge clk) begin
    if (frame_valid) begin
      mon_r.len        = frame_len;
      mon_r.crc_ok     = frame_crc_ok;
      mon_r.err        = frame_err;
      mon_r.runt       = frame_runt;
      mon_r.oversize   = frame_oversize;
      mon_r.trailer_ok = frame_trailer_ok;
      mon_r.seq        = frame_seq;
      mon_r.tx_sec     = frame_tx_sec;
      mon_r.tx_nsec    = frame_tx_nsec;
      mon_r.rx_sec     = frame_rx_sec;
      mon_r.rx_nsec    = frame_rx_nsec;
      recs.push_back(mon_r);
    end
    if (sof) sof_cnt++;
    if (pend_win && idle_octet) idle_obs++;
  end

  function automatic logic [31:0] ref_crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fbk;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fbk = r[0] ^ b[i];
      r   = {1'b0, r[31:1]};
      if (fbk) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (fb[i]) c = ref_crc_byte(c, fb[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fb.push_back(c[i*8 +: 8]);
  endtask

  task automatic build_gen(input logic [63:0] seq, input logic [47:0] ts,
                           input logic [31:0] tn, input int npay);
    fb.delete();
    for (int i = 0; i < npay; i++) fb.push_back(8'(i));
    for (int i = 7; i >= 0; i--) fb.push_back(seq[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(ts[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fb.push_back(tn[i*8 +: 8]);
    add_fcs();
  endtask

  task automatic drive(input logic en, input logic [7:0] d, input logic er, input logic r);
    @(negedge clk);
    nsec    = nsec + 30'd8;
    rst     = r;
    gmii_en = en;
    gmii_d  = d;
    gmii_er = er;
    in_win  = burst_on;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int npre, input logic [7:0] sfd, input int er_idx, input int rst_idx);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, sfd, 1'b0, 1'b0);
    sfd_sec  = sec;
    sfd_nsec = nsec;
    foreach (fb[i]) drive(1'b1, fb[i], 1'(i == er_idx), 1'(i == rst_idx));
  endtask

  task automatic expect_rec(input string tag, input logic [15:0] len, input logic crc_ok,
                            input logic err, input logic runt, input logic over, input logic tok,
                            input logic [63:0] seq, input logic [47:0] txs, input logic [29:0] txn);
    rec_t r;
    check({tag, ".count"}, 64'(recs.size()), 64'd1);
    if (recs.size() > 0) begin
      r = recs.pop_front();
      check({tag, ".len"},      64'(r.len),        64'(len));
      check({tag, ".crc_ok"},   64'(r.crc_ok),     64'(crc_ok));
      check({tag, ".err"},      64'(r.err),        64'(err));
      check({tag, ".runt"},     64'(r.runt),       64'(runt));
      check({tag, ".oversize"}, 64'(r.oversize),   64'(over));
      check({tag, ".trl_ok"},   64'(r.trailer_ok), 64'(tok));
      check({tag, ".seq"},      r.seq,             seq);
      check({tag, ".tx_sec"},   64'(r.tx_sec),     64'(txs));
      check({tag, ".tx_nsec"},  64'(r.tx_nsec),    64'(txn));
      check({tag, ".rx_sec"},   64'(r.rx_sec),     64'(sfd_sec));
      check({tag, ".rx_nsec"},  64'(r.rx_nsec),    64'(sfd_nsec));
    end
    recs.delete();
  endtask

  initial begin
    rec_t r;
    rst = 1'b1; gmii_en = 1'b0; gmii_d = 8'h00; gmii_er = 1'b0;
    sec = 48'h0000_1234_5678; nsec = 30'd1000;

    repeat (3) @(negedge clk);
    check("rst.valid",  64'(frame_valid), 64'd0);
    check("rst.len",    64'(frame_len),   64'd0);
    check("rst.idle",   64'(idle_octet),  64'd0);
    check("rst.sof",    64'(sof),         64'd0);
    check("rst.seq",    frame_seq,        64'd0);
    check("rst.rx_ns",  64'(frame_rx_nsec), 64'd0);
    idle(4);
    check("idle.pulse", 64'(idle_octet),  64'd1);

    build_gen(64'd3, 48'h12, 32'h0000_1F40, 42);
    send_frame(7, 8'hD5, -1, -1);
    idle(12);
    expect_rec("gen", 16'd64, 1, 0, 0, 0, 1, 64'd3, 48'h12, 30'd8000);
    check("gen.sof_cnt", 64'(sof_cnt), 64'd1);
    idle(20);
    check("hold.len", 64'(frame_len), 64'd64);
    check("hold.seq", frame_seq,      64'd3);

    build_gen(64'd3, 48'h12, 32'h0000_1F40, 42);
    fb[10] = fb[10] ^ 8'h04;
    send_frame(7, 8'hD5, -1, -1);
    idle(12);
    expect_rec("flip", 16'd64, 0, 0, 0, 0, 1, 64'd3, 48'h12, 30'd8000);

    burst_on = 1'b1;
    for (int k = 0; k < 10; k++) begin
      build_gen(64'(k), 48'h12, 32'h0000_1F40, 42);
      send_frame(7, 8'hD5, -1, -1);
      idle((k % 2 == 0) ? 20 : 84);
    end
    burst_on = 1'b0;
    idle(4);
    check("burst.count", 64'(recs.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      if (recs.size() > 0) begin
        r = recs.pop_front();
        check($sformatf("burst%0d.seq", k), r.seq, 64'(k));
        check($sformatf("burst%0d.crc", k), 64'(r.crc_ok), 64'd1);
        check($sformatf("burst%0d.len", k), 64'(r.len), 64'd64);
      end
    end
    recs.delete();
    check("burst.idle_octets", 64'(idle_obs), 64'd520);

    build_gen(64'h30, 48'h12, 32'h0000_1F40, 42);
    send_frame(7, 8'hD5, 30, -1);
    idle(12);
    expect_rec("er", 16'd64, 1, 1, 0, 0, 1, 64'h30, 48'h12, 30'd8000);
    build_gen(64'h31, 48'h12, 32'h0000_1F40, 42);
    send_frame(7, 8'hD5, -1, -1);
    idle(12);
    expect_rec("after_er", 16'd64, 1, 0, 0, 0, 1, 64'h31, 48'h12, 30'd8000);

    build_gen(64'h40, 48'h12, 32'h0000_1F40, 42);
    send_frame(8, 8'hD5, -1, -1);
    idle(12);
    check("pre8.count", 64'(recs.size()), 64'd0);
    send_frame(7, 8'h57, -1, -1);
    idle(12);
    check("sfd57.count", 64'(recs.size()), 64'd0);
    check("bad.hold_seq", frame_seq, 64'h31);
    recs.delete();

    fb.delete();
    for (int i = 0; i < 16; i++) fb.push_back(8'(8'hA0 + i));
    add_fcs();
    send_frame(7, 8'hD5, -1, -1);
    idle(12);
    expect_rec("runt20", 16'd20, 1, 0, 1, 0, 0, 64'd0, 48'd0, 30'd0);

    build_gen(64'hA1B2_C3D4_E5F6_0718, 48'hABCD_EF01_2345, 32'hFFFF_FFFF, 0);
    send_frame(7, 8'hD5, -1, -1);
    idle(12);
    expect_rec("len22", 16'd22, 1, 0, 1, 0, 1, 64'hA1B2_C3D4_E5F6_0718,
               48'hABCD_EF01_2345, 30'h3FFF_FFFF);

    build_gen(64'h55AA, 48'h1, 32'h2, 1497);
    send_frame(7, 8'hD5, -1, -1);
    idle(12);
    expect_rec("over1519", 16'd1519, 1, 0, 0, 1, 1, 64'h55AA, 48'h1, 30'h2);

    build_gen(64'h66, 48'h12, 32'h0000_1F40, 42);
    send_frame(7, 8'hD5, -1, 40);
    idle(12);
    check("rst_mid.count", 64'(recs.size()), 64'd0);
    build_gen(64'h77, 48'h12, 32'h0000_1F40, 42);
    send_frame(7, 8'hD5, -1, -1);
    idle(12);
    expect_rec("post_rst", 16'd64, 1, 0, 0, 0, 1, 64'h77, 48'h12, 30'd8000);
    check("total.sof_cnt", 64'(sof_cnt), 64'd19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
